// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the memory bus between I and D clients and steers accept/return tags to the owning client.
module mem_bus_arbiter #(
   parameter int NUM_TAGS        = 16,
   parameter int MAX_OUTSTANDING = 8,
   parameter int STARVE_LIMIT    = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  Icache2arb_command,
   input  logic [63:0] Icache2arb_addr,
   input  logic [1:0]  Dcache2arb_command,
   input  logic [63:0] Dcache2arb_addr,
   input  logic [63:0] Dcache2arb_data,
   output logic [1:0]  proc2mem_command,
   output logic [63:0] proc2mem_addr,
   output logic [63:0] proc2mem_data,
   input  logic [3:0]  mem2proc_response,
   input  logic [63:0] mem2proc_data,
   input  logic [3:0]  mem2proc_tag,
   output logic [3:0]  Imem2proc_response,
   output logic [3:0]  Dmem2proc_response,
   output logic [3:0]  Imem2proc_tag,
   output logic [3:0]  Dmem2proc_tag,
   output logic [63:0] mem2proc_data_out,
   output logic [3:0]  outstanding_cnt,
   output logic        spurious_tag_err
);
   localparam logic [1:0] BUS_NONE = 2'd0;
   localparam logic [1:0] BUS_LOAD = 2'd1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [NUM_TAGS-1:0] valid_q, valid_d, owner_q, owner_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [SW-1:0]       starve_q, starve_d;
   logic                err_q, err_d;
   logic                load_ok, i_raw, i_req, d_req, i_gnt, d_gnt, acc, ret, dup;

   // Loads become ineligible once every in-flight slot is used; stores never are.
   assign load_ok = cnt_q != 4'(MAX_OUTSTANDING);
   assign i_raw   = Icache2arb_command != BUS_NONE;
   assign i_req   = i_raw && (Icache2arb_command != BUS_LOAD || load_ok);
   assign d_req   = Dcache2arb_command != BUS_NONE && (Dcache2arb_command != BUS_LOAD || load_ok);
   assign d_gnt   = reset && d_req && (starve_q < SW'(STARVE_LIMIT) || !i_req);
   assign i_gnt   = reset && i_req && !d_gnt;

   assign proc2mem_command   = i_gnt ? Icache2arb_command : d_gnt ? Dcache2arb_command : BUS_NONE;
   assign proc2mem_addr      = i_gnt ? Icache2arb_addr : d_gnt ? Dcache2arb_addr : 64'd0;
   assign proc2mem_data      = d_gnt ? Dcache2arb_data : 64'd0;
   assign Imem2proc_response = i_gnt ? mem2proc_response : 4'd0;
   assign Dmem2proc_response = d_gnt ? mem2proc_response : 4'd0;

   assign acc = proc2mem_command == BUS_LOAD && mem2proc_response != 4'd0;
   assign ret = mem2proc_tag != 4'd0 && valid_q[mem2proc_tag];
   // An accept on a live tag is a protocol violation unless that same tag retires this cycle.
   assign dup = acc && valid_q[mem2proc_response] && !(ret && mem2proc_tag == mem2proc_response);

   assign Imem2proc_tag     = ret && !owner_q[mem2proc_tag] ? mem2proc_tag : 4'd0;
   assign Dmem2proc_tag     = ret && owner_q[mem2proc_tag] ? mem2proc_tag : 4'd0;
   assign mem2proc_data_out = mem2proc_data;
   assign outstanding_cnt   = cnt_q;
   assign spurious_tag_err  = err_q;

   always_comb begin
      valid_d = valid_q;
      owner_d = owner_q;
      if (ret) valid_d[mem2proc_tag] = 1'b0;
      if (acc) begin
         valid_d[mem2proc_response] = 1'b1;
         owner_d[mem2proc_response] = d_gnt;
      end
      cnt_d    = cnt_q + {3'd0, acc && !dup} - {3'd0, ret};
      starve_d = (!i_raw || i_gnt) ? '0 : starve_q == SW'(STARVE_LIMIT) ? starve_q : starve_q + 1'b1;
      err_d    = err_q || (mem2proc_tag != 4'd0 && !valid_q[mem2proc_tag]) || dup;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q  <= '0;
         owner_q  <= '0;
         cnt_q    <= '0;
         starve_q <= '0;
         err_q    <= 1'b0;
      end else begin
         valid_q  <= valid_d;
         owner_q  <= owner_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
         err_q    <= err_d;
      end
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed bench; accepted loads go to a scoreboard that later drives and checks the returns.
module tb_mem_bus_arbiter;
   localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;

   logic        clock, reset;
   logic [1:0]  icmd, dcmd, p_cmd;
   logic [63:0] iaddr, daddr, ddata, p_addr, p_data, mdata, mdata_o;
   logic [3:0]  resp, rtag, iresp, dresp, itag, dtag, cnt;
   logic        err;

   typedef struct {logic [3:0] tag; logic d;} exp_t;
   exp_t sb[$];
   exp_t e;
   int total = 0, bad = 0;

   mem_bus_arbiter dut (
      .clock(clock), .reset(reset),
      .Icache2arb_command(icmd), .Icache2arb_addr(iaddr),
      .Dcache2arb_command(dcmd), .Dcache2arb_addr(daddr), .Dcache2arb_data(ddata),
      .proc2mem_command(p_cmd), .proc2mem_addr(p_addr), .proc2mem_data(p_data),
      .mem2proc_response(resp), .mem2proc_data(mdata), .mem2proc_tag(rtag),
      .Imem2proc_response(iresp), .Dmem2proc_response(dresp),
      .Imem2proc_tag(itag), .Dmem2proc_tag(dtag),
      .mem2proc_data_out(mdata_o), .outstanding_cnt(cnt), .spurious_tag_err(err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic drv(input logic [1:0] ic, input logic [63:0] ia, input logic [1:0] dc,
                      input logic [63:0] da, input logic [63:0] dd, input logic [3:0] rs, input logic [3:0] rt);
      icmd = ic; iaddr = ia; dcmd = dc; daddr = da; ddata = dd; resp = rs; rtag = rt;
      mdata = {32'hC0DE0000, 28'd0, rt};
      #2;
   endtask

   task automatic drain;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         drv(NONE, 0, NONE, 0, 0, 0, e.tag);
         chk("ret_itag", itag, e.d ? 4'd0 : e.tag);
         chk("ret_dtag", dtag, e.d ? e.tag : 4'd0);
         chk("ret_data", mdata_o, mdata);
         tick();
      end
      chk("drain_cnt", cnt, 0);
   endtask

   initial begin
      reset = 1'b0;
      drv(NONE, 0, NONE, 0, 0, 0, 0);
      repeat (2) tick();
      drv(LOAD, 64'h100, NONE, 0, 0, 3, 3);
      chk("rst_cmd", p_cmd, NONE);
      chk("rst_addr", p_addr, 0);
      chk("rst_iresp", iresp, 0);
      chk("rst_itag", itag, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_err", err, 0);
      drv(NONE, 0, NONE, 0, 0, 0, 0);
      reset = 1'b1;
      tick();
      // I-only load, returned five cycles later
      drv(LOAD, 64'h100, NONE, 0, 0, 3, 0);
      chk("i_cmd", p_cmd, LOAD);
      chk("i_addr", p_addr, 64'h100);
      chk("i_data", p_data, 0);
      chk("i_iresp", iresp, 3);
      chk("i_dresp", dresp, 0);
      sb.push_back('{tag: 4'd3, d: 1'b0});
      tick();
      drv(NONE, 0, NONE, 0, 0, 0, 0);
      chk("i_cnt1", cnt, 1);
      repeat (4) tick();
      drain();
      // contention: D wins four times, then I is forced through once
      for (int k = 0; k < 6; k++) begin
         logic exp_d;
         exp_d = (k != 4);
         drv(LOAD, 64'h1000 + 64'(k), LOAD, 64'h2000 + 64'(k), 0, 4'(k + 1), 0);
         chk("cont_dresp", dresp, exp_d ? 4'(k + 1) : 4'd0);
         chk("cont_iresp", iresp, exp_d ? 4'd0 : 4'(k + 1));
         chk("cont_addr", p_addr, exp_d ? 64'h2000 + 64'(k) : 64'h1000 + 64'(k));
         sb.push_back('{tag: 4'(k + 1), d: exp_d});
         tick();
      end
      chk("cont_cnt", cnt, 6);
      drain();
      // D store bypasses the tag table
      drv(NONE, 0, STORE, 64'h2000, 64'hDEADBEEF, 5, 0);
      chk("st_cmd", p_cmd, STORE);
      chk("st_data", p_data, 64'hDEADBEEF);
      chk("st_dresp", dresp, 5);
      tick();
      drv(NONE, 0, NONE, 0, 0, 0, 0);
      chk("st_cnt", cnt, 0);
      // fill to the outstanding limit
      for (int k = 1; k <= 8; k++) begin
         drv(NONE, 0, LOAD, 64'h3000 + 64'(k), 0, 4'(k), 0);
         chk("fill_cmd", p_cmd, LOAD);
         sb.push_back('{tag: 4'(k), d: 1'b1});
         tick();
      end
      chk("fill_cnt", cnt, 8);
      drv(LOAD, 64'h3100, LOAD, 64'h3009, 0, 9, 0);
      chk("full_cmd", p_cmd, NONE);
      chk("full_dresp", dresp, 0);
      chk("full_iresp", iresp, 0);
      tick();
      drv(NONE, 0, STORE, 64'h4000, 64'h55, 10, 0);
      chk("full_st_cmd", p_cmd, STORE);
      chk("full_st_dresp", dresp, 10);
      tick();
      chk("full_cnt", cnt, 8);
      e = sb.pop_front();
      drv(NONE, 0, LOAD, 64'h3009, 0, 0, e.tag);
      chk("full_ret_cmd", p_cmd, NONE);
      chk("full_ret_dtag", dtag, e.tag);
      tick();
      chk("reopen_cnt", cnt, 7);
      drv(NONE, 0, LOAD, 64'h3009, 0, 1, 0);
      chk("reopen_cmd", p_cmd, LOAD);
      chk("reopen_dresp", dresp, 1);
      sb.push_back('{tag: 4'd1, d: 1'b1});
      tick();
      chk("refill_cnt", cnt, 8);
      drain();
      // same-cycle return and re-accept of tag 7 with a new owner
      drv(LOAD, 64'h500, NONE, 0, 0, 7, 0);
      chk("same_iresp", iresp, 7);
      tick();
      drv(NONE, 0, LOAD, 64'h600, 0, 7, 7);
      chk("same_itag", itag, 7);
      chk("same_dtag", dtag, 0);
      chk("same_dresp", dresp, 7);
      tick();
      chk("same_cnt", cnt, 1);
      chk("same_err", err, 0);
      sb.push_back('{tag: 4'd7, d: 1'b1});
      drain();
      // spurious return is sticky
      drv(NONE, 0, NONE, 0, 0, 0, 9);
      chk("spur_itag", itag, 0);
      chk("spur_dtag", dtag, 0);
      tick();
      drv(NONE, 0, NONE, 0, 0, 0, 0);
      chk("spur_err", err, 1);
      repeat (2) tick();
      chk("spur_err_hold", err, 1);
      // async reset mid-operation drops ownership
      for (int t = 1; t <= 3; t++) begin
         drv(LOAD, 64'h700 + 64'(t), NONE, 0, 0, 4'(t), 0);
         tick();
      end
      chk("pre_rst_cnt", cnt, 3);
      drv(LOAD, 64'h800, NONE, 0, 0, 4, 0);
      reset = 1'b0;
      #1;
      chk("mid_rst_cnt", cnt, 0);
      chk("mid_rst_err", err, 0);
      chk("mid_rst_cmd", p_cmd, NONE);
      chk("mid_rst_iresp", iresp, 0);
      tick();
      reset = 1'b1;
      drv(NONE, 0, NONE, 0, 0, 0, 2);
      chk("post_rst_itag", itag, 0);
      chk("post_rst_dtag", dtag, 0);
      tick();
      drv(NONE, 0, NONE, 0, 0, 0, 0);
      chk("post_rst_err", err, 1);
      chk("post_rst_cnt", cnt, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
